// File: rtl/acc_soc_pkg.sv
// Shared SoC definitions for the CGRA packet path.
// Packet/beat widths, packet struct, pack/unpack helpers.
package acc_soc_pkg;

   localparam int CGRA_PKT_W    = 185;
   localparam int AXI_DATA_W    = 64;
   localparam int AXIS_W        = 192;
   localparam int BEATS_PER_PKT = AXIS_W / AXI_DATA_W;
   localparam int PAD_W         = AXIS_W - CGRA_PKT_W;

   typedef struct packed {
      logic [PAD_W-1:0]      pad;
      logic [CGRA_PKT_W-1:0] body;
   } cgra_pkt_t;

   function automatic logic [AXIS_W-1:0] pkt_pack(
      input cgra_pkt_t p
   );
      return {{PAD_W{1'b0}}, p.body};
   endfunction

   function automatic cgra_pkt_t pkt_unpack(
      input logic [AXIS_W-1:0] w
   );
      return cgra_pkt_t'(w);
   endfunction

endpackage

// File: rtl/pkt_fifo2.sv
// Two-entry packet FIFO with head/tail pointers.
// Ports: push/din write, pop retires head, dout = head, occ = 0..2.
module pkt_fifo2
   import acc_soc_pkg::*;
#(
   parameter int W = AXIS_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);

   logic [W-1:0] mem_q [2];
   logic [W-1:0] mem_d [2];
   logic         wptr_q, wptr_d;
   logic         rptr_q, rptr_d;
   logic [1:0]   occ_q, occ_d;

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         mem_d[wptr_q] = din;
         wptr_d        = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
      occ_d = occ_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '{default: '0};
         wptr_q <= 1'b0;
         rptr_q <= 1'b0;
         occ_q  <= 2'd0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         occ_q  <= occ_d;
      end
   end

   assign dout = mem_q[rptr_q];
   assign occ  = occ_q;

endmodule

// File: rtl/axis_pkt_serializer.sv
// Wide AXIS packet -> BEAT_W AXI beats, LSB beat first, 2-packet buffer.
// Ports: s_* wide in, m_* beats out, pkt_cnt/pad_err status, clr, busy.
module axis_pkt_serializer
   import acc_soc_pkg::*;
#(
   parameter int PKT_W   = AXIS_W,
   parameter int BEAT_W  = AXI_DATA_W,
   parameter int VALID_W = CGRA_PKT_W,
   parameter int CNT_W   = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PKT_W-1:0]    s_tdata,
   input  logic                s_tvalid,
   output logic                s_tready,
   output logic [BEAT_W-1:0]   m_tdata,
   output logic [BEAT_W/8-1:0] m_tstrb,
   output logic                m_tlast,
   output logic                m_tvalid,
   input  logic                m_tready,
   output logic [CNT_W-1:0]    pkt_cnt,
   output logic                pad_err,
   input  logic                clr,
   output logic                busy
);

   localparam int BEATS  = PKT_W / BEAT_W;
   localparam int BIW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int NSTRB  = BEAT_W / 8;
   localparam int VBYTES = (VALID_W + 7) / 8;

   function automatic logic [PKT_W-1:0] valid_mask();
      logic [PKT_W-1:0] m;
      for (int i = 0; i < PKT_W; i++) begin
         m[i] = (i < VALID_W);
      end
      return m;
   endfunction

   localparam logic [PKT_W-1:0] VMASK = valid_mask();

   logic [1:0]       occ;
   logic [PKT_W-1:0] head;
   logic             push, pop;
   logic             beat_hs, last_beat;
   logic             pad_hit;

   logic [BIW-1:0]   beat_idx_q, beat_idx_d;
   logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic             pad_err_q, pad_err_d;

   // rst gates ready so nothing is taken while the buffer is held clear
   assign s_tready  = ~rst & (occ != 2'd2);
   assign push      = s_tvalid & s_tready;
   assign m_tvalid  = (occ != 2'd0);
   assign busy      = m_tvalid;
   assign last_beat = (beat_idx_q == BIW'(BEATS - 1));
   assign beat_hs   = m_tvalid & m_tready;
   assign pop       = beat_hs & last_beat;
   assign pad_hit   = |(s_tdata & ~VMASK);

   // padding is stripped on entry so it never reaches m_tdata
   pkt_fifo2 #(
      .W (PKT_W)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  (s_tdata & VMASK),
      .dout (head),
      .occ  (occ)
   );

   always_comb begin
      beat_idx_d = beat_idx_q;
      pkt_cnt_d  = pkt_cnt_q;
      pad_err_d  = pad_err_q;
      if (beat_hs) begin
         if (last_beat) begin
            beat_idx_d = '0;
            pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
         end else begin
            beat_idx_d = beat_idx_q + BIW'(1);
         end
      end
      if (clr) begin
         pkt_cnt_d = '0;
         pad_err_d = 1'b0;
      end
      if (push && pad_hit) begin
         pad_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_idx_q <= '0;
         pkt_cnt_q  <= '0;
         pad_err_q  <= 1'b0;
      end else begin
         beat_idx_q <= beat_idx_d;
         pkt_cnt_q  <= pkt_cnt_d;
         pad_err_q  <= pad_err_d;
      end
   end

   always_comb begin
      m_tdata = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (beat_idx_q == BIW'(k)) begin
            m_tdata = head[k*BEAT_W +: BEAT_W];
         end
      end
   end

   // strobe off for bytes past the last meaningful packet byte
   always_comb begin
      m_tstrb = '0;
      for (int j = 0; j < NSTRB; j++) begin
         m_tstrb[j] = m_tvalid &&
            ((int'(beat_idx_q) * NSTRB + j) < VBYTES);
      end
   end

   assign m_tlast = m_tvalid & last_beat;
   assign pkt_cnt = pkt_cnt_q;
   assign pad_err = pad_err_q;

endmodule

// File: doc/axis_pkt_serializer.md
Name: axis_pkt_serializer

Overview:
Transmit-side width downsizer for the CGRA packet stream. It accepts one padded CGRA packet per wide AXIS transfer (AXIS_W = 192) from the CGRA bridge. It emits that packet as BEATS_PER_PKT AXI-data-width beats (64 b), LSB beat first, with tlast and tstrb, for the DMA TX engine's AXI W channel. It is the counterpart of the RX-path beat-to-packet assembly and includes two-packet buffering for bubble-free back-to-back streaming.

Parameters:
- PKT_W, 192, wide input width; must be a multiple of BEAT_W.
- BEAT_W, 64, output beat width (AXI data width).
- VALID_W, 185, meaningful packet bits (CGRA packet width); bits [PKT_W-1:VALID_W] are padding.
- CNT_W, 32, packet counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  PKT_W  packed packet, LSB-aligned.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  BEAT_W  current beat.
- m_tstrb  out  BEAT_W/8  byte strobes.
- m_tlast  out  1  final beat of the packet.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- pkt_cnt  out  CNT_W  count of fully sent packets.
- pad_err  out  1  sticky: an accepted packet had nonzero padding bits.
- clr  in  1  synchronous clear of pkt_cnt and pad_err.
- busy  out  1  buffer non-empty.

Behaviour:
- BEATS = PKT_W/BEAT_W (3). Beat k carries packet bits [k*BEAT_W +: BEAT_W].
- Padding bits are forced to 0 on m_tdata regardless of the input value.
- Storage: 2-entry packet FIFO (head/tail pointers, 2-bit occupancy) plus beat index beat_idx in 0..BEATS-1.
- Input handshake: accept when s_tvalid && s_tready.
  - s_tready = (occupancy < 2).
  - s_tready depends on registered state only; there is no combinational path from m_tready or s_tvalid.
- Output:
  - m_tvalid = (occupancy != 0).
  - m_tdata = head entry sliced by beat_idx.
  - m_tlast = (beat_idx == BEATS-1).
  - Outputs are muxed from registers only.
- Strobes: m_tstrb is all-ones except bytes at or beyond ceil(VALID_W/8) = 24, which are 0. With the defaults every beat is 8'hFF.
- Beat handshake (m_tvalid && m_tready):
  - Not the last beat: beat_idx increments.
  - Last beat: beat_idx returns to 0, the head entry is popped, and pkt_cnt increments.
- AXIS stability: once m_tvalid is asserted, m_tvalid and m_tdata/m_tstrb/m_tlast hold until the handshake completes.
- Latency: a packet accepted at cycle N shows beat 0 at cycle N+1 when the FIFO was empty.
- Throughput: with m_tready held high, packets stream with no idle cycle between the last beat of one packet and beat 0 of the next.
- Occupancy boundaries:
  - Push and pop in the same cycle leave occupancy unchanged.
  - Push at occupancy 2 is impossible because s_tready is 0.
  - Pop at occupancy 0 is impossible because m_tvalid is 0.
- pkt_cnt wraps modulo 2^CNT_W.
- clr and a last-beat handshake in the same cycle: clr wins, and pkt_cnt reads 0 on the next cycle.
- pad_err:
  - Set on an accepted packet with any nonzero s_tdata[PKT_W-1:VALID_W].
  - Set has priority over a simultaneous clr.
  - Cleared only by clr or rst.
- busy = (occupancy != 0).
- Reset (async, any time including mid-packet):
  - Occupancy, pointers, beat_idx, pkt_cnt and pad_err go to 0, and buffered packets are discarded.
  - Output reset values: m_tvalid=0, m_tlast=0, m_tdata=0, m_tstrb=0 (strobes gated by m_tvalid), busy=0, pad_err=0, pkt_cnt=0, s_tready=0 while rst is high and 1 after release.

Decomposition:
- Shared package (acc_soc_pkg):
  - CGRA_PKT_W = 185, AXI_DATA_W = 64, BEATS_PER_PKT, AXIS_W = 192.
  - The packet struct typedef and pack/unpack functions live there as well, so the bridge, DMA and this block share one definition.
- One sub-module: pkt_fifo2, a parameterized 2-entry FIFO of width PKT_W exposing occupancy, head data, push and pop.

Test Plan:
- Single packet, s_tdata = {7'h0, 57'hA, 64'h5555..., 64'h1234_5678_9ABC_DEF0}, m_tready=1 → beats on cycles N+1 to N+3 with values 0x123456789ABCDEF0, 0x5555..., 0xA; tlast only on the third beat; tstrb=FF each beat; pkt_cnt=1; busy falls after the third beat.
- 4 back-to-back packets, m_tready=1 → 12 contiguous beats with no m_tvalid gap; tlast on beats 3, 6, 9, 12; pkt_cnt=4.
- Backpressure: m_tready=0 for 5 cycles starting at beat 1 while s_tvalid stays high → m_tvalid and data stable; s_tready=0 after 2 packets buffered; resumes in order with no loss or duplication.
- Padding: s_tdata[191:185]=7'h41 → pad_err=1 next cycle; beat 2 bits [63:57]=0; pad_err stays 1 until clr pulse, then reads 0.
- Reset pulse after beat 0 of a packet (second packet buffered) → all outputs 0 during reset and pkt_cnt=0; the next packet after release starts at beat 0.
- clr asserted in the same cycle as a last-beat handshake → pkt_cnt reads 0 next cycle (not 1); the following packet gives pkt_cnt=1.
